// File: rtl/imem_arb.sv
// Single-port instruction RAM shared between fetch (read-only) and a loader/debug port.
// Define IMEM_ARB_RR_EN for round-robin contention; otherwise fetch wins contention.
module imem_arb #(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          f_req_i,
   input  logic [AW-1:0] f_addr_i,
   output logic          f_gnt_o,
   output logic          f_rvalid_o,
   output logic [DW-1:0] f_rdata_o,
   input  logic          l_req_i,
   input  logic          l_we_i,
   input  logic [AW-1:0] l_addr_i,
   input  logic [DW-1:0] l_wdata_i,
   input  logic          l_lock_i,
   output logic          l_gnt_o,
   output logic          l_rvalid_o,
   output logic [DW-1:0] l_rdata_o,
   output logic          busy_o
);

   localparam int DEPTH = 1 << AW;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic          f_gnt, l_gnt;
   logic          loader_wins;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] ram_rdata_q;
   logic          ram_we, ram_re;
   logic [AW-1:0] ram_addr;

   logic          f_rvalid_q, f_rvalid_d;
   logic          l_rvalid_q, l_rvalid_d;
   logic [DW-1:0] f_hold_q, f_hold_d;
   logic [DW-1:0] l_hold_q, l_hold_d;

`ifdef IMEM_ARB_RR_EN
   // last_l_q = 1 when the loader took the most recent grant
   logic last_l_q, last_l_d;

   always_comb begin
      last_l_d = last_l_q;
      if (l_gnt) begin
         last_l_d = 1'b1;
      end else if (f_gnt) begin
         last_l_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_l_q <= 1'b1;
      end else begin
         last_l_q <= last_l_d;
      end
   end

   assign loader_wins = ~last_l_q;
`else
   assign loader_wins = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      f_gnt   = 1'b0;
      l_gnt   = 1'b0;
      case (state_q)
         ST_ARB: begin
            if (f_req_i && l_req_i) begin
               l_gnt = loader_wins;
               f_gnt = ~loader_wins;
            end else begin
               f_gnt = f_req_i;
               l_gnt = l_req_i;
            end
            if (l_gnt && l_lock_i) begin
               state_d = ST_LOCK;
            end
         end
         ST_LOCK: begin
            // The release cycle still grants under LOCK rules
            l_gnt = l_req_i;
            if (!l_lock_i) begin
               state_d = ST_ARB;
            end
         end
         default: begin
            state_d = ST_ARB;
         end
      endcase
      if (!reset_n_i) begin
         f_gnt = 1'b0;
         l_gnt = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_ARB;
      end else begin
         state_q <= state_d;
      end
   end

   // Grants are mutually exclusive, so one shared address/enable set drives the RAM
   assign ram_we   = l_gnt & l_we_i;
   assign ram_re   = f_gnt | (l_gnt & ~l_we_i);
   assign ram_addr = l_gnt ? l_addr_i : f_addr_i;

   always_ff @(posedge clk_i) begin
      if (ram_we) begin
         mem_q[ram_addr] <= l_wdata_i;
      end
      if (ram_re) begin
         ram_rdata_q <= mem_q[ram_addr];
      end
   end

   always_comb begin
      f_rvalid_d = f_gnt;
      l_rvalid_d = l_gnt & ~l_we_i;
      f_hold_d   = f_rvalid_q ? ram_rdata_q : f_hold_q;
      l_hold_d   = l_rvalid_q ? ram_rdata_q : l_hold_q;
   end

   // Hold registers keep each port's last word once the shared RAM register moves on
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         f_rvalid_q <= 1'b0;
         l_rvalid_q <= 1'b0;
         f_hold_q   <= '0;
         l_hold_q   <= '0;
      end else begin
         f_rvalid_q <= f_rvalid_d;
         l_rvalid_q <= l_rvalid_d;
         f_hold_q   <= f_hold_d;
         l_hold_q   <= l_hold_d;
      end
   end

   assign f_gnt_o    = f_gnt;
   assign l_gnt_o    = l_gnt;
   assign f_rvalid_o = f_rvalid_q;
   assign l_rvalid_o = l_rvalid_q;
   assign f_rdata_o  = f_rvalid_q ? ram_rdata_q : f_hold_q;
   assign l_rdata_o  = l_rvalid_q ? ram_rdata_q : l_hold_q;
   assign busy_o     = (state_q == ST_LOCK);

endmodule

// File: doc/imem_arb.md
# imem_arb

Single-port instruction-memory owner and arbiter for the pipelined MIPS core. It holds the 2^AW x DW instruction RAM and shares its one access port between the fetch stage (read-only) and a program loader/debug port (read/write). The loader can take exclusive ownership for burst program loads, stalling fetch. Reads return with fixed one-cycle latency.

## Interface
- AW, 8, word-address width; RAM depth 2^AW words
- DW, 32, data width

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- f_req  in  1  fetch read request; held until granted
- f_addr  in  AW  fetch word address; stable while f_req=1
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  f_rdata valid; pulses one cycle after f_gnt
- f_rdata  out  DW  fetched word
- l_req  in  1  loader request; held until granted
- l_we  in  1  1 = write, 0 = read
- l_addr  in  AW  loader word address
- l_wdata  in  DW  write data
- l_lock  in  1  request or hold exclusive ownership
- l_gnt  out  1  loader request accepted this cycle
- l_rvalid  out  1  l_rdata valid; pulses one cycle after a granted loader read
- l_rdata  out  DW  loader read data
- busy  out  1  1 while in LOCK state

## Operation
- One RAM access per cycle. Grant is combinational from the current requests and state. The access is performed on the same clock edge.
- A request transfers on the cycle where req=1 and gnt=1. Requesters may drop or change req/addr only after gnt.
- FSM states: ARB (reset) and LOCK.
  - ARB: if exactly one requester asserts, it is granted. If both assert, arbitration applies (see Configuration).
  - ARB -> LOCK: when l_gnt=1 and l_lock=1.
  - LOCK: f_gnt=0 and l_gnt=l_req. busy=1.
  - LOCK -> ARB: on the first edge where l_lock=0. The grant in that cycle still follows LOCK rules.
- Writes: RAM[l_addr] <= l_wdata at the grant edge. No l_rvalid is produced.
- Reads: the registered read of RAM[addr] appears on the requester's rdata with rvalid=1 in the following cycle. rdata holds its value until the next read for that port.
- Read of an address written in the previous cycle returns the new data. Writes and reads never occur in the same cycle.
- Addresses are word indices. There is no wrap beyond 2^AW-1 because addresses are exactly AW bits.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed by the system):
  - f_gnt, l_gnt, f_rvalid, l_rvalid, and busy are 0.
  - f_rdata and l_rdata are 0.
  - State is ARB. The round-robin pointer favours fetch.
  - RAM contents are not reset.
- Grants are forced to 0 while reset_n=0.
- Read latency is exactly 1 cycle from the grant edge. Throughput is 1 access per cycle total.
- Reset mid-operation: a response due the cycle after reset asserts is discarded; rvalid stays 0. A LOCK in progress is abandoned and the state returns to ARB.
- Simultaneous f_req and l_req with l_lock=1 in ARB: the arbitration rule decides. LOCK is entered only if the loader wins.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin arbitration in ARB. A 1-bit last-winner register is updated on every grant. On contention, the requester that did not win last is granted, so the two ports alternate under continuous contention.
- IMEM_ARB_RR_EN undefined: fixed priority, and fetch always wins contention in ARB. The loader can be starved unless fetch idles; LOCK behaviour is unchanged.

## Test plan
- Reset, then loader write 0x20000001 to addr 0. Next cycle, fetch addr 0 -> f_gnt=1, then f_rvalid=1 with f_rdata=0x20000001 one cycle later; l_rvalid stays 0 throughout.
- Continuous f_req and l_req (read, addr 5) for 4 cycles, with RR_EN: grants are F, L, F, L and l_rdata=RAM[5]. Without RR_EN: f_gnt=1 for all 4 cycles and l_gnt=0.
- Loader burst writes to addr 1..4 with l_lock=1 while f_req=1: busy=1, f_gnt=0 for 4 cycles. l_lock drops -> busy=0 next cycle, f_gnt=1 the first cycle in ARB, and a fetch of addr 4 returns the last written word.
- Write 0xDEADBEEF to addr 255, then loader read addr 255 the next cycle -> l_rvalid=1 with l_rdata=0xDEADBEEF; the write cycle produces no rvalid.
- f_gnt for addr 0, then reset_n=0 the next cycle -> f_rvalid=0, f_rdata=0, busy=0. After release, a fresh fetch returns data normally.
- Reset asserted while in LOCK -> busy=0 immediately. After release, with l_lock=1 held but l_req=0, f_req is granted (state is ARB).
